// File: rtl/regfile_wb_arbiter.sv
// Write-port owner for register_file: clears every register after reset, then
// round-robin arbitrates ALU and MEM writebacks onto the port, suppressing x0 writes.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS   = 32,
  parameter bit          INIT_CLEAR = 1'b1
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  alu_valid_i,
  input  logic [ADDR_WIDTH-1:0] alu_rd_i,
  input  logic [DATA_WIDTH-1:0] alu_data_i,
  output logic                  alu_ready_o,
  input  logic                  mem_valid_i,
  input  logic [ADDR_WIDTH-1:0] mem_rd_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  mem_ready_o,
  output logic                  reg_write_o,
  output logic [ADDR_WIDTH-1:0] wr_register_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  init_done_o
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;
  typedef enum logic {PRIO_ALU, PRIO_MEM} prio_e;

  localparam logic [ADDR_WIDTH:0] LAST_IDX    = (ADDR_WIDTH + 1)'(NUM_REGS - 1);
  localparam state_e              RESET_STATE = INIT_CLEAR ? ST_INIT : ST_RUN;

  state_e                state_q, state_d;
  prio_e                 prio_q, prio_d;
  logic [ADDR_WIDTH:0]   clr_cnt_q, clr_cnt_d;
  logic                  reg_write_q, reg_write_d;
  logic [ADDR_WIDTH-1:0] wr_register_q, wr_register_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  init_done_q, init_done_d;

  logic run_active;
  logic alu_xfer;
  logic mem_xfer;

  // Readies are gated by reset_i directly so they drop the moment reset asserts.
  always_comb begin
    run_active  = (state_q == ST_RUN) && !reset_i;
    alu_ready_o = run_active && alu_valid_i && (!mem_valid_i || prio_q == PRIO_ALU);
    mem_ready_o = run_active && mem_valid_i && (!alu_valid_i || prio_q == PRIO_MEM);
    alu_xfer    = alu_valid_i && alu_ready_o;
    mem_xfer    = mem_valid_i && mem_ready_o;
  end

  always_comb begin
    state_d       = state_q;
    prio_d        = prio_q;
    clr_cnt_d     = clr_cnt_q;
    reg_write_d   = 1'b0;
    wr_register_d = wr_register_q;
    wr_data_d     = wr_data_q;
    init_done_d   = init_done_q;
    case (state_q)
      ST_INIT: begin
        reg_write_d   = 1'b1;
        wr_register_d = clr_cnt_q[ADDR_WIDTH-1:0];
        wr_data_d     = '0;
        clr_cnt_d     = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_IDX) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        init_done_d = 1'b1;
        if (alu_xfer) begin
          reg_write_d   = (alu_rd_i != '0);
          wr_register_d = alu_rd_i;
          wr_data_d     = alu_data_i;
          prio_d        = PRIO_MEM;
        end else if (mem_xfer) begin
          reg_write_d   = (mem_rd_i != '0);
          wr_register_d = mem_rd_i;
          wr_data_d     = mem_data_i;
          prio_d        = PRIO_ALU;
        end
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= RESET_STATE;
      prio_q        <= PRIO_ALU;
      clr_cnt_q     <= '0;
      reg_write_q   <= 1'b0;
      wr_register_q <= '0;
      wr_data_q     <= '0;
      init_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      prio_q        <= prio_d;
      clr_cnt_q     <= clr_cnt_d;
      reg_write_q   <= reg_write_d;
      wr_register_q <= wr_register_d;
      wr_data_q     <= wr_data_d;
      init_done_q   <= init_done_d;
    end
  end

  assign reg_write_o   = reg_write_q;
  assign wr_register_o = wr_register_q;
  assign wr_data_o     = wr_data_q;
  assign init_done_o   = init_done_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: INIT clear, arbitration vector table, x0 suppression,
// reset mid-run, and the no-clear variant, with write results checked through a queue.
module tb_regfile_wb_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: INIT_CLEAR = 1
  logic        rst_a;
  logic        a_av, a_mv, a_ardy, a_mrdy, a_we, a_done;
  logic [4:0]  a_ard, a_mrd, a_wa;
  logic [31:0] a_ad, a_md, a_wd;

  // DUT B: INIT_CLEAR = 0
  logic        rst_b;
  logic        b_av, b_mv, b_ardy, b_mrdy, b_we, b_done;
  logic [4:0]  b_ard, b_mrd, b_wa;
  logic [31:0] b_ad, b_md, b_wd;

  regfile_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32), .INIT_CLEAR(1'b1)) dut_a (
    .clock_i(clk), .reset_i(rst_a),
    .alu_valid_i(a_av), .alu_rd_i(a_ard), .alu_data_i(a_ad), .alu_ready_o(a_ardy),
    .mem_valid_i(a_mv), .mem_rd_i(a_mrd), .mem_data_i(a_md), .mem_ready_o(a_mrdy),
    .reg_write_o(a_we), .wr_register_o(a_wa), .wr_data_o(a_wd), .init_done_o(a_done)
  );

  regfile_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32), .INIT_CLEAR(1'b0)) dut_b (
    .clock_i(clk), .reset_i(rst_b),
    .alu_valid_i(b_av), .alu_rd_i(b_ard), .alu_data_i(b_ad), .alu_ready_o(b_ardy),
    .mem_valid_i(b_mv), .mem_rd_i(b_mrd), .mem_data_i(b_md), .mem_ready_o(b_mrdy),
    .reg_write_o(b_we), .wr_register_o(b_wa), .wr_data_o(b_wd), .init_done_o(b_done)
  );

  // Simple register_file stand-in fed by DUT A's write port
  logic [31:0] rf [32];
  always @(posedge clk) if (a_we) rf[a_wa] <= a_wd;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        ardy;
    logic        mrdy;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } vec_t;
  vec_t tbl[12];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_write(input logic we, input logic [4:0] wa, input logic [31:0] wd);
    wr_t e;
    e.we = we; e.wa = wa; e.wd = wd;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input string tag, input logic we, input logic [4:0] wa,
                           input logic [31:0] wd);
    wr_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got we=%b wa=%0d wd=%h", tag, we, wa, wd);
    end else begin
      n_checks--;
      e = exp_q.pop_front();
      chk({tag, "_we"}, 32'(we), 32'(e.we));
      chk({tag, "_wa"}, 32'(wa), 32'(e.wa));
      chk({tag, "_wd"}, wd, e.wd);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 32 clear cycles on DUT A; requesters may hold valid throughout
  task automatic run_init(input string tag);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("%s_ardy%0d", tag, i), 32'(a_ardy), 32'd0);
      chk($sformatf("%s_mrdy%0d", tag, i), 32'(a_mrdy), 32'd0);
      push_write(1'b1, 5'(i), 32'h0);
      tick();
      pop_check($sformatf("%s_clr%0d", tag, i), a_we, a_wa, a_wd);
      chk($sformatf("%s_done%0d", tag, i), 32'(a_done), (i == 31) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 5'd1,  32'h55555555, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 5'd1,  32'h55555555};
    tbl[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd1,  32'h55555555};
    tbl[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4, 32'hCAFEF00D, 1'b0, 1'b1, 1'b1, 5'd4,  32'hCAFEF00D};
    tbl[3]  = '{1'b1, 5'd2,  32'hAAAAAAAA, 1'b1, 5'd3, 32'h12345678, 1'b1, 1'b0, 1'b1, 5'd2,  32'hAAAAAAAA};
    tbl[4]  = '{1'b1, 5'd2,  32'hAAAAAAAA, 1'b1, 5'd3, 32'h12345678, 1'b0, 1'b1, 1'b1, 5'd3,  32'h12345678};
    tbl[5]  = '{1'b1, 5'd2,  32'hAAAAAAAA, 1'b1, 5'd3, 32'h12345678, 1'b1, 1'b0, 1'b1, 5'd2,  32'hAAAAAAAA};
    tbl[6]  = '{1'b1, 5'd2,  32'hAAAAAAAA, 1'b1, 5'd3, 32'h12345678, 1'b0, 1'b1, 1'b1, 5'd3,  32'h12345678};
    tbl[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 5'd0,  32'hFFFFFFFF};
    tbl[8]  = '{1'b1, 5'd5,  32'h00000005, 1'b1, 5'd6, 32'h00000066, 1'b1, 1'b0, 1'b1, 5'd5,  32'h00000005};
    tbl[9]  = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 5'd0,  32'h00001234};
    tbl[10] = '{1'b1, 5'd7,  32'h00000077, 1'b1, 5'd8, 32'h00000088, 1'b0, 1'b1, 1'b1, 5'd8,  32'h00000088};
    tbl[11] = '{1'b1, 5'd31, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 5'd31, 32'hDEADBEEF};

    rst_a = 1'b1; rst_b = 1'b1;
    a_av = 1'b1; a_ard = 5'd1; a_ad = 32'h00000BAD;
    a_mv = 1'b1; a_mrd = 5'd2; a_md = 32'h00000BAD;
    b_av = 1'b0; b_ard = '0; b_ad = '0;
    b_mv = 1'b0; b_mrd = '0; b_md = '0;

    // Reset state with valids high
    #2;
    chk("rst_we",   32'(a_we),   32'd0);
    chk("rst_wa",   32'(a_wa),   32'd0);
    chk("rst_wd",   a_wd,        32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_ardy", 32'(a_ardy), 32'd0);
    chk("rst_mrdy", 32'(a_mrdy), 32'd0);
    tick();
    rst_a = 1'b0;

    run_init("init");
    a_av = 1'b0; a_mv = 1'b0;

    // Arbitration / writeback vector table
    for (int i = 0; i < 12; i++) begin
      a_av = tbl[i].av; a_ard = tbl[i].ard; a_ad = tbl[i].ad;
      a_mv = tbl[i].mv; a_mrd = tbl[i].mrd; a_md = tbl[i].md;
      #1;
      chk($sformatf("row%0d_ardy", i), 32'(a_ardy), 32'(tbl[i].ardy));
      chk($sformatf("row%0d_mrdy", i), 32'(a_mrdy), 32'(tbl[i].mrdy));
      push_write(tbl[i].we, tbl[i].wa, tbl[i].wd);
      tick();
      pop_check($sformatf("row%0d", i), a_we, a_wa, a_wd);
    end

    chk("rf_x0", rf[0], 32'h0);
    chk("rf_x1", rf[1], 32'h55555555);
    chk("rf_x2", rf[2], 32'hAAAAAAAA);
    chk("rf_x3", rf[3], 32'h12345678);
    chk("rf_x4", rf[4], 32'hCAFEF00D);
    chk("rf_x9", rf[9], 32'h0);

    // Reset mid-cycle in RUN while MEM holds a request
    a_av = 1'b0; a_mv = 1'b1; a_mrd = 5'd9; a_md = 32'h00000099;
    #2;
    rst_a = 1'b1;
    #1;
    chk("mid_rst_we",   32'(a_we),   32'd0);
    chk("mid_rst_wa",   32'(a_wa),   32'd0);
    chk("mid_rst_wd",   a_wd,        32'd0);
    chk("mid_rst_done", 32'(a_done), 32'd0);
    chk("mid_rst_mrdy", 32'(a_mrdy), 32'd0);
    tick();
    chk("held_rst_we", 32'(a_we), 32'd0);
    rst_a = 1'b0;
    run_init("reinit");
    #1;
    chk("post_init_mrdy", 32'(a_mrdy), 32'd1);
    chk("post_init_ardy", 32'(a_ardy), 32'd0);
    push_write(1'b1, 5'd9, 32'h00000099);
    tick();
    pop_check("held_req", a_we, a_wa, a_wd);
    a_mv = 1'b0;
    push_write(1'b0, 5'd9, 32'h00000099);
    tick();
    pop_check("idle_hold", a_we, a_wa, a_wd);

    // No-clear variant
    rst_b = 1'b0;
    chk("b_done_pre", 32'(b_done), 32'd0);
    tick();
    chk("b_done_1", 32'(b_done), 32'd1);
    chk("b_we_1",   32'(b_we),   32'd0);
    tick();
    chk("b_we_2",   32'(b_we),   32'd0);
    b_av = 1'b1; b_ard = 5'd1; b_ad = 32'h55555555;
    #1;
    chk("b_ardy", 32'(b_ardy), 32'd1);
    chk("b_mrdy", 32'(b_mrdy), 32'd0);
    push_write(1'b1, 5'd1, 32'h55555555);
    tick();
    pop_check("b_wr", b_we, b_wa, b_wd);
    b_av = 1'b0;
    push_write(1'b0, 5'd1, 32'h55555555);
    tick();
    pop_check("b_idle", b_we, b_wa, b_wd);
    chk("b_done_hold", 32'(b_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
